// File: rtl/alu_pkg.sv
// Shared ALU opcodes, datapath width and multiply sequencer state encoding.
package alu_pkg;

    localparam int N = 16;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mult_seq_if.sv
// Start/done handshake and shared-ALU borrow bus of the multiply sequencer.
interface alu_mult_seq_if #(
    parameter int N = alu_pkg::N
);
    logic         start;
    logic         kill;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         busy;
    logic         done;
    logic [N-1:0] product;
    logic         alu_req;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_op;
    logic         alu_cin;
    logic [N-1:0] alu_out;

    modport master (
        output start, kill, op_a, op_b, alu_out,
        input  busy, done, product,
        input  alu_req, alu_a, alu_b, alu_op, alu_cin
    );

    modport slave (
        input  start, kill, op_a, op_b, alu_out,
        output busy, done, product,
        output alu_req, alu_a, alu_b, alu_op, alu_cin
    );
endinterface

// File: rtl/alu_mult_seq.sv
// Shift-add multiplier that borrows the shared ALU for one ADD per multiplier bit.
// Define ALU_MULT_EARLY_EXIT_EN to stop once the remaining multiplier bits are 0.
module alu_mult_seq #(
    parameter int N  = alu_pkg::N,
    parameter int CW = 5
) (
    input logic          clk,
    input logic          rst,
    alu_mult_seq_if.slave bus
);
    import alu_pkg::*;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  acc;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mplr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  product;
    logic          busy;
    logic          done;
    logic          alu_req;
    logic [2:0]    alu_op;
    logic          last;
    logic          accept;

    assign accept = bus.start && !bus.kill;

    always_comb begin
        last = (cnt == CW'(N - 1));
`ifdef ALU_MULT_EARLY_EXIT_EN
        last = last || (mplr[N-1:1] == '0);
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (bus.kill) state_nxt = IDLE;
                     else if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_req <= 1'b0;
            alu_op  <= '0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            alu_req <= (state_nxt == RUN);
            alu_op  <= (state_nxt == RUN) ? ALU_ADD : 3'b000;
            if (state == IDLE && accept) begin
                acc   <= '0;
                mcand <= bus.op_a;
                mplr  <= bus.op_b;
                cnt   <= '0;
            end
            // A kill abandons the iteration, leaving product untouched.
            if (state == RUN && !bus.kill) begin
                acc   <= bus.alu_out;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt + CW'(1);
                if (last) product <= bus.alu_out;
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product;
    assign bus.alu_req = alu_req;
    assign bus.alu_op  = alu_op;
    assign bus.alu_cin = 1'b0;
    assign bus.alu_a   = alu_req ? acc : '0;
    assign bus.alu_b   = (alu_req && mplr[0]) ? mcand : '0;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed bench for alu_mult_seq with a behavioural shared-ALU model.
module tb_alu_mult_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

`ifdef ALU_MULT_EARLY_EXIT_EN
    localparam int KILL_AT = 1;
`else
    localparam int KILL_AT = 4;
`endif

    alu_mult_seq_if #(.N(16)) bus ();

    alu_mult_seq #(.N(16), .CW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.alu_out = (bus.alu_op == ALU_ADD) ?
        16'(bus.alu_a + bus.alu_b + 16'(bus.alu_cin)) : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_runs(input logic [15:0] b);
`ifdef ALU_MULT_EARLY_EXIT_EN
        int r;
        r = 1;
        for (int i = 0; i < 16; i++) if (b[i]) r = i + 1;
        return r;
`else
        return 16;
`endif
    endfunction

    task automatic mul(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] expv,
                       input bit noise);
        int n;
        int runs;
        int dones;
        int er;
        er = exp_runs(b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy_run"}, 32'(bus.busy), 32'd1);
        check({tag, " alu_op"}, 32'(bus.alu_op), 32'(ALU_ADD));
        check({tag, " alu_cin"}, 32'(bus.alu_cin), 32'd0);
        n = 0;
        runs = 0;
        while (!bus.done && n < 40) begin
            if (bus.alu_req) runs++;
            if (noise && n == 2) begin
                bus.start = 1'b1;
                bus.op_a  = 16'hFFFF;
                bus.op_b  = 16'hFFFF;
            end
            if (noise && n == 3) bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({tag, " done_seen"}, 32'(bus.done), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(er));
        check({tag, " run_cycles"}, 32'(runs), 32'(er));
        check({tag, " product"}, 32'(bus.product), 32'(expv));
        check({tag, " busy_done"}, 32'(bus.busy), 32'd1);
        check({tag, " alu_req_done"}, 32'(bus.alu_req), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (i == 0) check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        end
        check({tag, " extra_done"}, 32'(dones), 32'd0);
        check({tag, " product_held"}, 32'(bus.product), 32'(expv));
    endtask

    initial begin
        int dones;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;

        repeat (2) @(negedge clk);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst product", 32'(bus.product), 32'd0);
        check("rst alu_req", 32'(bus.alu_req), 32'd0);
        check("rst alu_a", 32'(bus.alu_a), 32'd0);
        check("rst alu_b", 32'(bus.alu_b), 32'd0);
        check("rst alu_op", 32'(bus.alu_op), 32'd0);
        check("rst alu_cin", 32'(bus.alu_cin), 32'd0);
        rst = 1'b0;

        mul("3x5", 16'd3, 16'd5, 16'h000F, 1'b0);
        mul("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
        mul("1234x10", 16'h1234, 16'h0010, 16'h2340, 1'b0);
        mul("7x3", 16'd7, 16'h0003, 16'h0015, 1'b0);
        mul("55aax0", 16'h55AA, 16'h0000, 16'h0000, 1'b0);
        mul("1x8000", 16'h0001, 16'h8000, 16'h8000, 1'b0);

        // kill mid-run: product must stay 0x8000
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'd6;
        bus.op_b  = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (KILL_AT) @(negedge clk);
        check("kill alu_req_before", 32'(bus.alu_req), 32'd1);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill busy", 32'(bus.busy), 32'd0);
        check("kill alu_req", 32'(bus.alu_req), 32'd0);
        check("kill alu_a", 32'(bus.alu_a), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("kill no_done", 32'(dones), 32'd0);
        check("kill product", 32'(bus.product), 32'h8000);
        mul("2x9", 16'd2, 16'd9, 16'h0012, 1'b0);

        mul("ignored_start", 16'd5, 16'h8007, 16'h8023, 1'b1);

        // start and kill together in IDLE
        @(negedge clk);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        bus.op_a  = 16'd9;
        bus.op_b  = 16'd9;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check("startkill busy", 32'(bus.busy), 32'd0);
        check("startkill alu_req", 32'(bus.alu_req), 32'd0);
        repeat (3) @(negedge clk);
        check("startkill stay", 32'(bus.busy), 32'd0);

        // asynchronous reset between edges mid-run
        bus.start = 1'b1;
        bus.op_a  = 16'd3;
        bus.op_b  = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("arst busy_before", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst busy", 32'(bus.busy), 32'd0);
        check("arst done", 32'(bus.done), 32'd0);
        check("arst alu_req", 32'(bus.alu_req), 32'd0);
        check("arst product", 32'(bus.product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mul("4x4", 16'd4, 16'd4, 16'h0010, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
